// File: rtl/axi_addr_remap_ctrl.sv
// AW/AR address remap front-end for axi_modify_address: base/mask/offset table,
// per-channel capture FSM holding a stable translated address until handshake.
// Ports: clk_i, rst_ni (sync, active-low); slv_{aw,ar}_{valid_i,addr_i,ready_o};
//   mst_{aw,ar}_{valid_o,ready_i,addr_o}; {aw,ar}_miss_o; cfg_{we,idx,field,wdata}_i.
// Option AXI_REMAP_MISS_CNT_EN: adds miss_cnt_o[15:0] and miss_cnt_clr_i.
module axi_addr_remap_ctrl #(
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = 32,
  parameter int unsigned NumRules     = 4,
  localparam int unsigned CfgWidth =
    (SlvAddrWidth > MstAddrWidth) ? SlvAddrWidth : MstAddrWidth,
  localparam int unsigned IdxWidth =
    (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    slv_aw_valid_i,
  input  logic [SlvAddrWidth-1:0] slv_aw_addr_i,
  output logic                    slv_aw_ready_o,
  output logic                    mst_aw_valid_o,
  input  logic                    mst_aw_ready_i,
  output logic [MstAddrWidth-1:0] mst_aw_addr_o,
  output logic                    aw_miss_o,
  input  logic                    slv_ar_valid_i,
  input  logic [SlvAddrWidth-1:0] slv_ar_addr_i,
  output logic                    slv_ar_ready_o,
  output logic                    mst_ar_valid_o,
  input  logic                    mst_ar_ready_i,
  output logic [MstAddrWidth-1:0] mst_ar_addr_o,
  output logic                    ar_miss_o,
  input  logic                    cfg_we_i,
  input  logic [IdxWidth-1:0]     cfg_idx_i,
  input  logic [1:0]              cfg_field_i,
  input  logic [CfgWidth-1:0]     cfg_wdata_i
`ifdef AXI_REMAP_MISS_CNT_EN
  ,
  output logic [15:0]             miss_cnt_o,
  input  logic                    miss_cnt_clr_i
`endif
);

  typedef enum logic {
    Idle,
    Hold
  } state_e;

  logic [SlvAddrWidth-1:0] base_q [NumRules];
  logic [SlvAddrWidth-1:0] mask_q [NumRules];
  logic [MstAddrWidth-1:0] offs_q [NumRules];
  logic [NumRules-1:0]     en_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRules; r++) begin
        base_q[r] <= '0;
        mask_q[r] <= '0;
        offs_q[r] <= '0;
      end
      en_q <= '0;
    end else if (cfg_we_i) begin
      for (int r = 0; r < NumRules; r++) begin
        if (cfg_idx_i == IdxWidth'(r)) begin
          unique case (cfg_field_i)
            2'd0:    base_q[r] <= cfg_wdata_i[SlvAddrWidth-1:0];
            2'd1:    mask_q[r] <= cfg_wdata_i[SlvAddrWidth-1:0];
            2'd2:    offs_q[r] <= cfg_wdata_i[MstAddrWidth-1:0];
            default: en_q[r]   <= cfg_wdata_i[0];
          endcase
        end
      end
    end
  end

  // Index 0 is AW, index 1 is AR.
  logic [1:0]              slv_valid;
  logic [1:0]              mst_ready;
  logic [1:0]              slv_ready;
  logic [SlvAddrWidth-1:0] slv_addr [2];

  assign slv_valid   = {slv_ar_valid_i, slv_aw_valid_i};
  assign mst_ready   = {mst_ar_ready_i, mst_aw_ready_i};
  assign slv_addr[0] = slv_aw_addr_i;
  assign slv_addr[1] = slv_ar_addr_i;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [MstAddrWidth-1:0] xlat;
    logic                    hit;
    logic                    cap_miss;
    state_e                  state_q;
    logic                    valid_q;
    logic                    miss_q;
    logic [MstAddrWidth-1:0] addr_q;

    // Walk high to low so the lowest matching index is the last assignment.
    always_comb begin
      hit  = 1'b0;
      xlat = MstAddrWidth'(slv_addr[c]);
      for (int r = NumRules - 1; r >= 0; r--) begin
        if (en_q[r] &&
            ((slv_addr[c] & mask_q[r]) == (base_q[r] & mask_q[r]))) begin
          hit  = 1'b1;
          xlat = MstAddrWidth'(CfgWidth'(offs_q[r]) +
                               CfgWidth'(slv_addr[c] & ~mask_q[r]));
        end
      end
    end

    assign cap_miss = (state_q == Idle) & slv_valid[c] & ~hit;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q <= Idle;
        valid_q <= 1'b0;
        miss_q  <= 1'b0;
        addr_q  <= '0;
      end else begin
        unique case (state_q)
          Idle: if (slv_valid[c]) begin
            state_q <= Hold;
            valid_q <= 1'b1;
            addr_q  <= xlat;
            miss_q  <= ~hit;
          end
          Hold: if (mst_ready[c]) begin
            state_q <= Idle;
            valid_q <= 1'b0;
          end
        endcase
      end
    end

    assign slv_ready[c] = valid_q & mst_ready[c];
  end

  assign slv_aw_ready_o = slv_ready[0];
  assign slv_ar_ready_o = slv_ready[1];
  assign mst_aw_valid_o = g_ch[0].valid_q;
  assign mst_ar_valid_o = g_ch[1].valid_q;
  assign mst_aw_addr_o  = g_ch[0].addr_q;
  assign mst_ar_addr_o  = g_ch[1].addr_q;
  assign aw_miss_o      = g_ch[0].miss_q;
  assign ar_miss_o      = g_ch[1].miss_q;

`ifdef AXI_REMAP_MISS_CNT_EN
  logic [15:0] miss_cnt_q;
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, miss_cnt_q} +
                   17'(g_ch[0].cap_miss) + 17'(g_ch[1].cap_miss);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || miss_cnt_clr_i) begin
      miss_cnt_q <= '0;
    end else if (cnt_sum[16]) begin
      miss_cnt_q <= 16'hFFFF;
    end else begin
      miss_cnt_q <= cnt_sum[15:0];
    end
  end

  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_cap;
  assign unused_cap = g_ch[0].cap_miss ^ g_ch[1].cap_miss;
`endif

endmodule

// File: tb/tb_axi_addr_remap_ctrl.sv
// Directed bench for axi_addr_remap_ctrl: reset, miss, hit, priority, wrap,
// hold stability, same-cycle write/capture, dual channel, reset in hold.
module tb_axi_addr_remap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_v, aw_r, maw_v, maw_r, aw_miss;
  logic        ar_v, ar_r, mar_v, mar_r, ar_miss;
  logic [31:0] aw_a, ar_a, maw_a, mar_a;
  logic        cfg_we;
  logic [1:0]  cfg_idx, cfg_field;
  logic [31:0] cfg_wdata;
`ifdef AXI_REMAP_MISS_CNT_EN
  logic [15:0] miss_cnt;
  logic        miss_clr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_addr_remap_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .slv_aw_valid_i (aw_v),
    .slv_aw_addr_i  (aw_a),
    .slv_aw_ready_o (aw_r),
    .mst_aw_valid_o (maw_v),
    .mst_aw_ready_i (maw_r),
    .mst_aw_addr_o  (maw_a),
    .aw_miss_o      (aw_miss),
    .slv_ar_valid_i (ar_v),
    .slv_ar_addr_i  (ar_a),
    .slv_ar_ready_o (ar_r),
    .mst_ar_valid_o (mar_v),
    .mst_ar_ready_i (mar_r),
    .mst_ar_addr_o  (mar_a),
    .ar_miss_o      (ar_miss),
    .cfg_we_i       (cfg_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_field_i    (cfg_field),
    .cfg_wdata_i    (cfg_wdata)
`ifdef AXI_REMAP_MISS_CNT_EN
    ,
    .miss_cnt_o     (miss_cnt),
    .miss_cnt_clr_i (miss_clr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int idx, input int f, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_field = 2'(f);
    cfg_wdata = d;
    tick;
    cfg_we    = 1'b0;
  endtask

  task automatic rule(input int idx, input logic [31:0] b,
                      input logic [31:0] m, input logic [31:0] o);
    cfg_wr(idx, 0, b);
    cfg_wr(idx, 1, m);
    cfg_wr(idx, 2, o);
    cfg_wr(idx, 3, 32'h1);
  endtask

  task automatic start(input bit ar, input logic [31:0] a);
    if (ar) begin ar_v = 1'b1; ar_a = a; end
    else    begin aw_v = 1'b1; aw_a = a; end
    tick;
  endtask

  task automatic done(input bit ar);
    if (ar) mar_r = 1'b1;
    else    maw_r = 1'b1;
    tick;
    if (ar) begin ar_v = 1'b0; mar_r = 1'b0; end
    else    begin aw_v = 1'b0; maw_r = 1'b0; end
  endtask

  initial begin
    rst_n = 1'b0;
    aw_v = 1'b0; aw_a = '0; maw_r = 1'b0;
    ar_v = 1'b0; ar_a = '0; mar_r = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
`ifdef AXI_REMAP_MISS_CNT_EN
    miss_clr = 1'b0;
`endif
    tick;
    tick;
    chk("rst_maw_v", maw_v, 0);
    chk("rst_mar_v", mar_v, 0);
    chk("rst_aw_r", aw_r, 0);
    chk("rst_ar_r", ar_r, 0);
    chk("rst_maw_a", maw_a, 0);
    chk("rst_mar_a", mar_a, 0);
    chk("rst_aw_miss", aw_miss, 0);
    chk("rst_ar_miss", ar_miss, 0);
`ifdef AXI_REMAP_MISS_CNT_EN
    chk("rst_cnt", miss_cnt, 0);
`endif
    rst_n = 1'b1;
    tick;

    // Empty table: pass-through with miss, one cycle latency.
    aw_v = 1'b1;
    aw_a = 32'h0000_1234;
    #1;
    chk("no_comb_valid", maw_v, 0);
    tick;
    chk("miss_valid", maw_v, 1);
    chk("miss_addr", maw_a, 32'h0000_1234);
    chk("miss_flag", aw_miss, 1);
    chk("miss_rdy_lo", aw_r, 0);
`ifdef AXI_REMAP_MISS_CNT_EN
    chk("cnt_1", miss_cnt, 1);
`endif
    maw_r = 1'b1;
    #1;
    chk("rdy_comb", aw_r, 1);
    tick;
    aw_v = 1'b0;
    maw_r = 1'b0;
    chk("hs_idle", maw_v, 0);

    rule(0, 32'h8000_0000, 32'hF000_0000, 32'h1000_0000);
    start(1, 32'h8000_0040);
    chk("hit_valid", mar_v, 1);
    chk("hit_addr", mar_a, 32'h1000_0040);
    chk("hit_miss", ar_miss, 0);
    done(1);
    chk("hit_idle", mar_v, 0);

    rule(1, 32'h8000_0000, 32'hF000_0000, 32'h2000_0000);
    start(1, 32'h8000_0040);
    chk("prio_addr", mar_a, 32'h1000_0040);
    done(1);

    start(1, 32'h9000_0040);
    chk("miss2_addr", mar_a, 32'h9000_0040);
    chk("miss2_flag", ar_miss, 1);
    done(1);

    // 0xFFFF_FF00 + 0x200 wraps to 0x100.
    rule(2, 32'hC000_0000, 32'hC000_0000, 32'hFFFF_FF00);
    start(1, 32'hC000_0200);
    chk("wrap_addr", mar_a, 32'h0000_0100);
    chk("wrap_miss", ar_miss, 0);
    done(1);

    // Stalled master while rule0 offset is rewritten.
    start(0, 32'h8000_0010);
    cfg_we = 1'b1;
    cfg_idx = 2'd0;
    cfg_field = 2'd2;
    cfg_wdata = 32'h3000_0000;
    for (int i = 0; i < 5; i++) begin
      chk("hold_addr", maw_a, 32'h1000_0010);
      chk("hold_rdy", aw_r, 0);
      tick;
    end
    cfg_we = 1'b0;
    chk("hold_valid", maw_v, 1);
    done(0);

    // Write and capture in the same edge: old table used.
    cfg_we = 1'b1;
    cfg_idx = 2'd0;
    cfg_field = 2'd2;
    cfg_wdata = 32'h4000_0000;
    start(0, 32'h8000_0010);
    cfg_we = 1'b0;
    chk("wr_cap_old", maw_a, 32'h3000_0010);
    done(0);
    start(0, 32'h8000_0010);
    chk("wr_cap_new", maw_a, 32'h4000_0010);
    done(0);

    cfg_wr(0, 3, 32'h0);
    start(1, 32'h8000_0040);
    chk("dis_r0", mar_a, 32'h2000_0040);
    done(1);

    // Both channels capture together, release separately.
    aw_v = 1'b1; aw_a = 32'h0000_1234;
    ar_v = 1'b1; ar_a = 32'h0000_5678;
    tick;
    chk("dual_aw_a", maw_a, 32'h0000_1234);
    chk("dual_ar_a", mar_a, 32'h0000_5678);
    chk("dual_aw_m", aw_miss, 1);
    chk("dual_ar_m", ar_miss, 1);
`ifdef AXI_REMAP_MISS_CNT_EN
    chk("cnt_dual", miss_cnt, 4);
`endif
    mar_r = 1'b1;
    #1;
    chk("dual_ar_r", ar_r, 1);
    chk("dual_aw_r", aw_r, 0);
    tick;
    ar_v = 1'b0;
    mar_r = 1'b0;
    chk("dual_ar_idle", mar_v, 0);
    chk("dual_aw_hold", maw_v, 1);
    done(0);
    chk("dual_aw_idle", maw_v, 0);

    // Reset during hold.
    start(0, 32'h8000_0010);
    chk("prerst_addr", maw_a, 32'h2000_0010);
    rst_n = 1'b0;
    tick;
    aw_v = 1'b0;
    chk("rst_hold_v", maw_v, 0);
    chk("rst_hold_a", maw_a, 0);
`ifdef AXI_REMAP_MISS_CNT_EN
    chk("rst_hold_cnt", miss_cnt, 0);
`endif
    rst_n = 1'b1;
    tick;
    start(1, 32'h8000_0040);
    chk("tbl_clr_addr", mar_a, 32'h8000_0040);
    chk("tbl_clr_miss", ar_miss, 1);
    done(1);

`ifdef AXI_REMAP_MISS_CNT_EN
    chk("cnt_post", miss_cnt, 1);
    miss_clr = 1'b1;
    tick;
    miss_clr = 1'b0;
    chk("cnt_clr", miss_cnt, 0);
    aw_v = 1'b1; aw_a = 32'h10; maw_r = 1'b1;
    ar_v = 1'b1; ar_a = 32'h20; mar_r = 1'b1;
    repeat (65534) tick;
    chk("cnt_fffe", miss_cnt, 16'hFFFE);
    tick;
    chk("cnt_sat", miss_cnt, 16'hFFFF);
    tick;
    tick;
    chk("cnt_sat_hold", miss_cnt, 16'hFFFF);
    tick;
    miss_clr = 1'b1;
    tick;
    miss_clr = 1'b0;
    chk("cnt_clr_prio", miss_cnt, 0);
    aw_v = 1'b0; ar_v = 1'b0;
    tick;
    maw_r = 1'b0; mar_r = 1'b0;
    chk("cnt_final", miss_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
